// File: rtl/md_unit.sv
`timescale 1ns / 1ps
// HI/LO multiply/divide unit: the result is formed when the op is accepted, held as pending,
// and written to HI/LO after the configured latency unless the op is cancelled first.
module md_unit #(
  parameter int unsigned W        = 32,
  parameter int unsigned MULT_LAT = 5,
  parameter int unsigned DIV_LAT  = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cancel,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] hi,
  output logic [W-1:0] lo
);

  localparam int unsigned DW = 2 * W;
  localparam logic [7:0] MultCnt = 8'(MULT_LAT - 1);
  localparam logic [7:0] DivCnt  = 8'(DIV_LAT - 1);

  typedef enum logic {StIdle, StBusy} state_e;

  state_e        state;
  logic [7:0]    count;
  logic [DW-1:0] pend;
  logic          pend_wr;

  logic [DW-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [DW-1:0] prod_s, prod_u, acc, res;
  logic [W-1:0]  b_safe, a_mag, b_mag;
  logic [W-1:0]  quo_u, rem_u, quo_m, rem_m, quo_s, rem_s;
  logic          b_nz, res_wr, is_mul, is_div;

  always_comb begin
    a_sx   = {{W{a[W-1]}}, a};
    b_sx   = {{W{b[W-1]}}, b};
    a_zx   = {{W{1'b0}}, a};
    b_zx   = {{W{1'b0}}, b};
    // Products are taken mod 2^(2W), so the sign-extended unsigned multiply is the signed product.
    prod_s = a_sx * b_sx;
    prod_u = a_zx * b_zx;
    // HI/LO cannot change while busy, so accumulating against them now equals doing it at commit.
    acc    = {hi, lo};

    b_nz   = (b != '0);
    b_safe = b_nz ? b : {{(W-1){1'b0}}, 1'b1};
    a_mag  = a[W-1] ? -a : a;
    b_mag  = b_safe[W-1] ? -b_safe : b_safe;
    quo_u  = a / b_safe;
    rem_u  = a % b_safe;
    quo_m  = a_mag / b_mag;
    rem_m  = a_mag % b_mag;
    // Magnitude division also covers MIN / -1: the quotient wraps back to MIN with remainder 0.
    quo_s  = (a[W-1] ^ b[W-1]) ? -quo_m : quo_m;
    rem_s  = a[W-1] ? -rem_m : rem_m;

    res    = acc;
    res_wr = 1'b1;
    is_mul = 1'b0;
    is_div = 1'b0;
    case (op)
      4'd1: begin is_mul = 1'b1; res = prod_s;       end
      4'd2: begin is_mul = 1'b1; res = prod_u;       end
      4'd3: begin
        is_div = 1'b1;
        res_wr = b_nz;
        res    = {rem_s, quo_s};
      end
      4'd4: begin
        is_div = 1'b1;
        res_wr = b_nz;
        res    = {rem_u, quo_u};
      end
      4'd5: begin is_mul = 1'b1; res = acc + prod_s; end
      4'd6: begin is_mul = 1'b1; res = acc + prod_u; end
      4'd7: begin is_mul = 1'b1; res = acc - prod_s; end
      4'd8: begin is_mul = 1'b1; res = acc - prod_u; end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= StIdle;
      count   <= '0;
      pend    <= '0;
      pend_wr <= 1'b0;
      done    <= 1'b0;
      hi      <= '0;
      lo      <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        StIdle: begin
          if (start && !cancel) begin
            if (is_mul || is_div) begin
              state   <= StBusy;
              count   <= is_div ? DivCnt : MultCnt;
              pend    <= res;
              pend_wr <= res_wr;
            end else if (op == 4'd9) begin
              hi <= a;
            end else if (op == 4'd10) begin
              lo <= a;
            end
          end
        end
        StBusy: begin
          if (cancel) begin
            state <= StIdle;
            count <= '0;
          end else if (count == '0) begin
            state <= StIdle;
            done  <= 1'b1;
            if (pend_wr) begin
              hi <= pend[DW-1:W];
              lo <= pend[W-1:0];
            end
          end else begin
            count <= count - 8'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  assign busy = (state == StBusy);

endmodule
